// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: NCH input channels in, one registered stream out.
// slave is the arbiter side; master is the side that drives channels and sinks the output.
interface rr_mux_arb_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 16,
    parameter int unsigned SEL_W = 4
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output mode,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid
    );
endinterface

// File: rtl/rr_mux_arb.sv
// N-channel mux with fixed-select or round-robin grant into a single registered output
// stage; the stage reloads in the same cycle it drains, so throughput is one word per cycle.
module rr_mux_arb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 16,
    parameter int unsigned SEL_W = 4
) (
    input logic         clk,
    input logic         rst,
    rr_mux_arb_if.slave bus
);

    logic                 w_load;
    logic                 w_fix_any;
    logic                 w_rr_any;
    logic                 w_grant_any;
    logic [SEL_W-1:0]     w_rr_idx;
    logic [SEL_W-1:0]     w_grant_idx;
    logic [SEL_W-1:0]     w_ptr_next;
    logic [SEL_W:0]       w_rr_sum;
    logic [2*NCH-1:0]     w_rot;
    logic [NCH-1:0]       w_grant_oh;
    logic [NCH-1:0]       w_in_ready;
    logic [WIDTH-1:0]     w_grant_data;

    logic [SEL_W-1:0]     r_ptr;
    logic [WIDTH-1:0]     r_out_data;
    logic [SEL_W-1:0]     r_out_ch;
    logic                 r_out_valid;

    assign w_load = !r_out_valid || bus.out_ready;

    // sel values at or above NCH match no channel, so they grant nothing.
    always_comb begin
        w_fix_any = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                w_fix_any = 1'b1;
            end
        end
    end

    // Bit j of w_rot is channel (ptr + j) mod NCH, so the lowest set bit is the winner.
    assign w_rot = {bus.in_valid, bus.in_valid} >> r_ptr;

    always_comb begin
        w_rr_any = 1'b0;
        w_rr_sum = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_rr_any = 1'b1;
                w_rr_sum = {1'b0, r_ptr} + (SEL_W + 1)'(j);
            end
        end
        if (w_rr_sum >= (SEL_W + 1)'(NCH)) begin
            w_rr_sum = w_rr_sum - (SEL_W + 1)'(NCH);
        end
        w_rr_idx = w_rr_sum[SEL_W-1:0];
    end

    assign w_grant_any = bus.mode ? w_rr_any : w_fix_any;
    assign w_grant_idx = bus.mode ? w_rr_idx : bus.sel;

    always_comb begin
        w_grant_oh   = '0;
        w_grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_grant_any && w_grant_idx == SEL_W'(i)) begin
                w_grant_oh[i] = 1'b1;
                w_grant_data  = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_in_ready = (rst || !w_load) ? '0 : w_grant_oh;
    assign w_ptr_next = (w_grant_idx == SEL_W'(NCH - 1)) ? '0 : w_grant_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_grant_any) begin
                r_out_data  <= w_grant_data;
                r_out_ch    <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (bus.mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: grants are checked as issued, output words through a queue.
module tb_rr_mux_arb;

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_fail;
    exp_t        exp_q[$];
    logic [15:0] chdata[16];

    rr_mux_arb_if #(.WIDTH(16), .NCH(16), .SEL_W(4)) bus ();
    rr_mux_arb_if #(.WIDTH(16), .NCH(12), .SEL_W(4)) bus12 ();

    rr_mux_arb #(.WIDTH(16), .NCH(16), .SEL_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rr_mux_arb #(.WIDTH(16), .NCH(12), .SEL_W(4)) u_dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // One cycle: apply inputs, check in_ready, optionally queue the expected word.
    task automatic step(input logic m, input logic [3:0] s, input logic [15:0] v,
                        input logic ordy, input logic [15:0] exp_rdy, input bit push);
        exp_t e;
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (push && exp_rdy != 16'h0) begin
            e.ch   = 4'(oh_idx(exp_rdy));
            e.data = chdata[oh_idx(exp_rdy)];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got ch %0d data %h expected none",
                         bus.out_ch, bus.out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
                chk("out_data", 32'(bus.out_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) chdata[i] = 16'h A000 + 16'(i * 16'h0111);
        chdata[3] = 16'hBEEF;
        for (int i = 0; i < 16; i++) bus.in_data[i*16 +: 16] = chdata[i];
        for (int i = 0; i < 12; i++) bus12.in_data[i*16 +: 16] = chdata[i];
        bus12.mode      = 1'b0;
        bus12.sel       = 4'h0;
        bus12.in_valid  = '0;
        bus12.out_ready = 1'b1;

        // Reset with every channel valid: nothing may be granted.
        rst           = 1'b1;
        bus.mode      = 1'b1;
        bus.sel       = 4'h0;
        bus.in_valid  = 16'hFFFF;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
        rst = 1'b0;

        // Fixed select, sel change taking effect immediately, then idle drain.
        step(1'b0, 4'd3, 16'h0008, 1'b1, 16'h0008, 1'b1);
        step(1'b0, 4'd7, 16'h0088, 1'b1, 16'h0080, 1'b1);
        step(1'b0, 4'd7, 16'h0008, 1'b1, 16'h0000, 1'b0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
        chk("drain_out_data_hold", 32'(bus.out_data), 32'(chdata[7]));
        chk("drain_out_ch_hold", 32'(bus.out_ch), 32'd7);

        // Round-robin, all valid: 0..15 then wrap to 0, one grant per cycle.
        for (int k = 0; k < 17; k++) begin
            step(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0001 << (k % 16), 1'b1);
        end

        // ptr=1 here; grant ch2 moves ptr to 3, then {2,5} alternate.
        step(1'b1, 4'd0, 16'h0004, 1'b1, 16'h0004, 1'b1);
        step(1'b1, 4'd0, 16'h0024, 1'b1, 16'h0020, 1'b1);
        step(1'b1, 4'd0, 16'h0024, 1'b1, 16'h0004, 1'b1);
        step(1'b1, 4'd0, 16'h0024, 1'b1, 16'h0020, 1'b1);

        // Backpressure on the ch5 word while mode/sel wander; then drain+reload at once.
        step(1'b1, 4'd0, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        chk("stall1_out_data", 32'(bus.out_data), 32'(chdata[5]));
        step(1'b0, 4'd2, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        chk("stall2_out_ch", 32'(bus.out_ch), 32'd5);
        step(1'b1, 4'd9, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        chk("stall3_out_data", 32'(bus.out_data), 32'(chdata[5]));
        chk("stall3_out_valid", 32'(bus.out_valid), 32'h1);
        step(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0040, 1'b1);
        chk("reload_out_ch", 32'(bus.out_ch), 32'd6);
        step(1'b1, 4'd0, 16'h0000, 1'b1, 16'h0000, 1'b0);
        chk("idle_out_valid", 32'(bus.out_valid), 32'h0);

        // 12-channel instance: sel beyond the channel count grants nothing.
        bus12.sel      = 4'hF;
        bus12.in_valid = 12'hFFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("n12_selF_in_ready", 32'(bus12.in_ready), 32'h0);
            @(posedge clk);
            #1;
            chk("n12_selF_out_valid", 32'(bus12.out_valid), 32'h0);
        end
        bus12.sel = 4'd11;
        #1;
        chk("n12_sel11_in_ready", 32'(bus12.in_ready), 32'h800);
        @(posedge clk);
        #1;
        bus12.in_valid = '0;
        chk("n12_out_valid", 32'(bus12.out_valid), 32'h1);
        chk("n12_out_ch", 32'(bus12.out_ch), 32'd11);
        chk("n12_out_data", 32'(bus12.out_data), 32'(chdata[11]));

        // ptr=7: ch8 lands in the register, then reset discards it.
        step(1'b1, 4'd0, 16'h0100, 1'b0, 16'h0100, 1'b0);
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
        chk("pre_rst_out_ch", 32'(bus.out_ch), 32'd8);
        rst          = 1'b1;
        bus.in_valid = 16'hFFFF;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("post_rst_out_data", 32'(bus.out_data), 32'h0);
        chk("post_rst_out_ch", 32'(bus.out_ch), 32'h0);
        rst = 1'b0;
        step(1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0001, 1'b1);
        step(1'b1, 4'd0, 16'h0000, 1'b1, 16'h0000, 1'b0);
        step(1'b1, 4'd0, 16'h0000, 1'b1, 16'h0000, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
